dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port data memory (combinational read, write on posedge clk, word-addressed via addr[9:2]).
- Requester 0 is the core load/store path; requester 1 is the debug/DMA loader.
- Latches one request per grant, drives the memory for one cycle, and returns registered read data with a valid pulse.

Parameters:
- DW, 32, data width of wdata/rdata/mem_wd/mem_rd.
- AW, 32, address width of m*_addr/mem_addr.
- RESET_PRIO, 0, requester favoured after reset (0 or 1).
- CNT_W, 16, width of grant counters (only used with DMEM_ARB_STATS_EN).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request, held until m0_gnt
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  AW  requester 0 byte address
- m0_wdata  in  DW  requester 0 write data
- m0_gnt  out  1  one-cycle accept pulse to requester 0
- m0_rvalid  out  1  one-cycle completion pulse to requester 0
- m0_rdata  out  DW  read data to requester 0, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meaning as m0_*, for requester 1
- mem_we  out  1  data memory write enable
- mem_addr  out  AW  data memory address
- mem_wd  out  DW  data memory write data
- mem_rd  in  DW  data memory combinational read data

Behaviour:
- Reset is asynchronous and active-low on rst_n.
  - All outputs go to 0 immediately.
  - FSM enters IDLE; prio is set to RESET_PRIO; latched request registers are cleared.
- FSM states: IDLE, ACCESS.
  - IDLE: if any req is high, select a winner. The winner's gnt is asserted combinationally in this cycle, its we/addr/wdata/id are latched, and the FSM goes to ACCESS. With no req, the FSM stays in IDLE.
  - ACCESS: lasts exactly one cycle, then returns to IDLE. No grant is issued while in ACCESS.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: requester prio wins.
  - On every grant, prio <= id of the non-winner (alternates under contention).
- Memory drive:
  - mem_addr and mem_wd always reflect the latched values.
  - mem_we = latched we AND (state == ACCESS). mem_we is 0 in IDLE.
- Completion:
  - At the end of the ACCESS cycle, mem_rd is registered into rdata of the latched id.
  - That id's rvalid pulses high for one cycle, the cycle after ACCESS.
  - rvalid also pulses for writes (write acknowledge); rdata then carries the pre-write word at that address.
  - The non-owner's rdata holds its previous value.
- Latency: gnt in cycle T, memory access in T+1, rvalid/rdata in T+2.
- Throughput: a new grant can occur in T+2, overlapping rvalid, giving one access per 2 cycles.
- The requester may change or drop req in the cycle after gnt. A req held high after gnt is treated as a new request.
- Address is passed through unmodified. Word alignment and address range are the memory's concern.
- Reset asserted during ACCESS: mem_we drops to 0 asynchronously, no rvalid is issued, and the in-flight access is lost.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs m0_gnt_cnt and m1_gnt_cnt (CNT_W each).
  - Each increments by 1 on its gnt and saturates at all-ones (no wrap).
  - Both clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then m0 read, addr 0x10, memory word 4 = 0xDEADBEEF -> m0_gnt at T, mem_we=0 and mem_addr=0x10 at T+1, m0_rvalid=1 with m0_rdata=0xDEADBEEF at T+2, m1_rvalid stays 0.
- m1 write addr 0x20, wdata 0x12345678, then m0 read 0x20 -> mem_we=1 only in m1's ACCESS cycle; m0_rdata=0x12345678.
- m0_req and m1_req held high for 8 cycles, RESET_PRIO=0 -> grants alternate m0, m1, m0, m1 (4 grants); rvalids follow each by 2 cycles.
- m0_req high alone continuously -> m0_gnt every 2nd cycle; prio toggles to 1, but m0 still wins each time.
- rst_n low mid-ACCESS of an m0 write -> mem_we falls to 0 immediately, no m0_rvalid, FSM in IDLE, prio=RESET_PRIO after release.
- DMEM_ARB_STATS_EN with CNT_W=2, 5 m1 grants -> m1_gnt_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester round-robin arbiter/sequencer for the single-port
//            data memory. Optional grant counters under DMEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int RESET_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [CNT_W-1:0] m0_gnt_cnt,
  output logic [CNT_W-1:0] m1_gnt_cnt,
`endif
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic c_reset_prio = (RESET_PRIO != 0);

  state_t        r_state;
  logic          r_prio;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic w_any;
  logic w_win;
  logic w_grant;

  assign w_any   = m0_req | m1_req;
  // Winner id: prio only matters when both requesters contend.
  assign w_win   = (m0_req & m1_req) ? r_prio : m1_req;
  // Gate with rst_n so the combinational grant is also forced low in reset.
  assign w_grant = rst_n & (r_state == S_IDLE) & w_any;

  assign m0_gnt    = w_grant & ~w_win;
  assign m1_gnt    = w_grant &  w_win;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_we    = r_we & (r_state == S_ACCESS);
  assign mem_addr  = r_addr;
  assign mem_wd    = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prio    <= c_reset_prio;
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_ACCESS;
            r_id    <= w_win;
            r_we    <= w_win ? m1_we    : m0_we;
            r_addr  <= w_win ? m1_addr  : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
            r_prio  <= ~w_win;
          end
        end
        S_ACCESS: begin
          // Memory read is combinational; capture it as the access retires.
          r_state <= S_IDLE;
          if (r_id) begin
            r_rvalid1 <= 1'b1;
            r_rdata1  <= mem_rd;
          end else begin
            r_rvalid0 <= 1'b1;
            r_rdata0  <= mem_rd;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (m0_gnt && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + c_cnt_one;
      if (m1_gnt && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + c_cnt_one;
    end
  end

  assign m0_gnt_cnt = r_cnt0;
  assign m1_gnt_cnt = r_cnt1;
`endif

endmodule
`default_nettype wire
